// File: rtl/hlu_pkg.sv
// rtl/hlu_pkg.sv - HI/LO unit op codes, FSM states and default latencies
package hlu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } hlu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } hlu_state_e;

  localparam int HLU_MULT_CYCLES = 5;
  localparam int HLU_DIV_CYCLES  = 10;
  localparam int HLU_CNT_W       = 4;

endpackage

// File: rtl/hlu_arith.sv
// rtl/hlu_arith.sv - combinational 64-bit {hi,lo} result for a multi-cycle HI/LO op
module hlu_arith
  import hlu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic [31:0] rt_nz;
  logic [31:0] q_s, r_s, q_u, r_u;

  assign prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
  assign prod_u = {32'd0, rs} * {32'd0, rt};
  assign acc    = {hi, lo};

  // Divisor forced non-zero so the datapath never sees x; rt==0 keeps HI/LO below.
  assign rt_nz = (rt == 32'd0) ? 32'd1 : rt;
  assign q_s   = $signed(rs) / $signed(rt_nz);
  assign r_s   = $signed(rs) % $signed(rt_nz);
  assign q_u   = rs / rt_nz;
  assign r_u   = rs % rt_nz;

  always_comb begin
    res = acc;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = (rt == 32'd0) ? acc : {r_s, q_s};
      OP_DIVU:  res = (rt == 32'd0) ? acc : {r_u, q_u};
      OP_MADD:  res = acc + prod_s;
      OP_MADDU: res = acc + prod_u;
      OP_MSUB:  res = acc - prod_s;
      OP_MSUBU: res = acc - prod_u;
      default:  res = acc;
    endcase
  end

endmodule

// File: rtl/hlu_ctrl.sv
// rtl/hlu_ctrl.sv - HI/LO unit sequencer: busy counter, HI/LO state, D-stage stall
// HLU_MADD_EN enables MADD/MADDU/MSUB/MSUBU; otherwise those codes decode as NOP.
module hlu_ctrl
  import hlu_pkg::*;
#(
  parameter int MULT_CYCLES = HLU_MULT_CYCLES,
  parameter int DIV_CYCLES  = HLU_DIV_CYCLES,
  parameter int CNT_W       = HLU_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [3:0]  E_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_isHLU,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hluResult,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  hlu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             is_mul;
  logic             is_div;
  logic             start;
  logic [63:0]      arith_res;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    case (E_op)
      OP_MULT, OP_MULTU: is_mul = 1'b1;
      OP_DIV, OP_DIVU:   is_div = 1'b1;
`ifdef HLU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b1;
`else
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_mul = 1'b0;
`endif
      default: ;
    endcase
  end

  assign start = (is_mul | is_div) & ~busy & ~Req;
  assign stall = D_isHLU & (busy | start);

  always_comb begin
    hluResult = 32'd0;
    if (E_op == OP_MFHI) hluResult = hi;
    else if (E_op == OP_MFLO) hluResult = lo;
  end

  hlu_arith u_arith (
    .op  (E_op),
    .rs  (E_rs),
    .rt  (E_rt),
    .hi  (hi),
    .lo  (lo),
    .res (arith_res)
  );

  // An in-flight op is older than any faulting instruction, so Req never aborts BUSY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state              <= S_BUSY;
            busy               <= 1'b1;
            cnt                <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            {pend_hi, pend_lo} <= arith_res;
          end else if (!Req) begin
            if (E_op == OP_MTHI) hi <= E_rs;
            else if (E_op == OP_MTLO) lo <= E_rs;
          end
        end
        S_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hlu_ctrl.sv
// tb/tb_hlu_ctrl.sv - directed scoreboard bench for hlu_ctrl
module tb_hlu_ctrl;
  import hlu_pkg::*;

  logic        clk;
  logic        reset;
  logic        Req;
  logic [3:0]  E_op;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_isHLU;
  logic        busy;
  logic        stall;
  logic [31:0] hluResult;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  hlu_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (Req),
    .E_op      (E_op),
    .E_rs      (E_rs),
    .E_rt      (E_rt),
    .D_isHLU   (D_isHLU),
    .busy      (busy),
    .stall     (stall),
    .hluResult (hluResult),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val);
    E_op = op;
    E_rs = val;
    tick();
    E_op = OP_NOP;
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [63:0] exp_v, input int n,
                        input int req_at, input int viol_at, input logic [3:0] viol_op);
    int cyc;
    logic [63:0] e;
    sb.push_back(exp_v);
    E_op = op;
    E_rs = rs;
    E_rt = rt;
    Req  = (req_at == 0);
    #1;
    chk({tag, "_stall_issue"}, 64'(stall), 64'(D_isHLU & (n != 0)));
    chk({tag, "_busy_issue"}, 64'(busy), 64'd0);
    tick();
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      E_op = (cyc == viol_at) ? viol_op : OP_NOP;
      E_rs = 32'hDEAD_BEEF;
      E_rt = 32'h0000_0003;
      Req  = (cyc == req_at);
      #1;
      chk({tag, "_stall_busy"}, 64'(stall), 64'(D_isHLU));
      tick();
    end
    E_op = OP_NOP;
    Req  = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
    e = sb.pop_front();
    chk({tag, "_hilo"}, {hi, lo}, e);
  endtask

  initial begin
    reset   = 1'b1;
    Req     = 1'b0;
    E_op    = OP_NOP;
    E_rs    = 32'd0;
    E_rt    = 32'd0;
    D_isHLU = 1'b1;
    tick();
    tick();
    E_op = OP_MFHI;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_result", 64'(hluResult), 64'd0);
    E_op  = OP_NOP;
    reset = 1'b0;
    tick();

    D_isHLU = 1'b0;
    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 5, -1, -1, OP_NOP);
    D_isHLU = 1'b1;
    run_op("divu", OP_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 10, -1, -1, OP_NOP);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5, -1, -1, OP_NOP);
    run_op("mult_min", OP_MULT, 32'h8000_0000, 32'd2, 64'hFFFF_FFFF_0000_0000, 5, -1, -1, OP_NOP);
    run_op("div_negrs", OP_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 10, -1, -1, OP_NOP);
    run_op("div_negrt", OP_DIV, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10, -1, -1, OP_NOP);

    mt(OP_MTHI, 32'h55);
    mt(OP_MTLO, 32'h55);
    chk("mt_hilo", {hi, lo}, {32'h55, 32'h55});
    run_op("div_zero", OP_DIV, 32'd9, 32'd0, {32'h55, 32'h55}, 10, -1, -1, OP_NOP);
    run_op("divu_zero", OP_DIVU, 32'd9, 32'd0, {32'h55, 32'h55}, 10, -1, -1, OP_NOP);

    run_op("mult_req", OP_MULT, 32'd2, 32'd3, {32'h55, 32'h55}, 0, 0, -1, OP_NOP);
    Req  = 1'b1;
    mt(OP_MTHI, 32'hAA);
    Req  = 1'b0;
    chk("mthi_req", 64'(hi), 64'h55);
    run_op("req_busy", OP_MULT, 32'd2, 32'd3, {32'd0, 32'd6}, 5, 2, -1, OP_NOP);
    run_op("req_last", OP_MULTU, 32'd4, 32'd5, {32'd0, 32'd20}, 5, 5, -1, OP_NOP);
    run_op("viol_mt", OP_MULT, 32'd3, 32'd3, {32'd0, 32'd9}, 5, -1, 2, OP_MTLO);
    run_op("viol_start", OP_DIVU, 32'd50, 32'd5, {32'd0, 32'd10}, 10, -1, 3, OP_MULT);

    mt(OP_MTLO, 32'h1234);
    E_op = OP_MFLO;
    #1;
    chk("mflo", 64'(hluResult), 64'h1234);
    chk("mflo_stall", 64'(stall), 64'd0);
    E_op = OP_MFHI;
    #1;
    chk("mfhi", 64'(hluResult), 64'd0);
    E_op = OP_NOP;
    #1;
    chk("nop_result", 64'(hluResult), 64'd0);

    E_op = OP_MULT;
    E_rs = 32'd2;
    E_rt = 32'd3;
    tick();
    E_op = OP_NOP;
    tick();
    tick();
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_hilo", {hi, lo}, 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);

    mt(OP_MTLO, 32'd10);
`ifdef HLU_MADD_EN
    run_op("madd", OP_MADD, 32'd2, 32'd3, {32'd0, 32'd16}, 5, -1, -1, OP_NOP);
    run_op("msubu", OP_MSUBU, 32'd1, 32'd20, 64'hFFFF_FFFF_FFFF_FFFC, 5, -1, -1, OP_NOP);
    run_op("msub", OP_MSUB, 32'hFFFF_FFFF, 32'd4, 64'h0000_0000_0000_0000, 5, -1, -1, OP_NOP);
`else
    run_op("madd", OP_MADD, 32'd2, 32'd3, {32'd0, 32'd10}, 0, -1, -1, OP_NOP);
    run_op("msubu", OP_MSUBU, 32'd1, 32'd20, {32'd0, 32'd10}, 0, -1, -1, OP_NOP);
    run_op("msub", OP_MSUB, 32'hFFFF_FFFF, 32'd4, {32'd0, 32'd10}, 0, -1, -1, OP_NOP);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
